// File: rtl/sqrt_nr_sequencer_if.sv
// ----------------------------------------------------------------------------
// sqrt_nr_sequencer_if
// Bundles the issue-side handshake (start/a in, busy/done/result/flags out)
// and the two shared-unit handshakes (divide, add) of sqrt_nr_sequencer.
//   slave  : sequencer view (issue/unit results in, requests/results out)
//   master : environment view (issue logic plus the divide/add units)
// Optional macro SQRT_RSQRT_EN adds op_rsqrt (captured with a).
// ----------------------------------------------------------------------------
interface sqrt_nr_sequencer_if;
    logic        start;
    logic [31:0] a;
`ifdef SQRT_RSQRT_EN
    logic        op_rsqrt;
`endif
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        exception;
    logic        div_start;
    logic [31:0] div_n1;
    logic [31:0] div_n2;
    logic        div_done;
    logic [31:0] div_result;
    logic        add_start;
    logic [31:0] add_n1;
    logic [31:0] add_n2;
    logic        add_done;
    logic [31:0] add_result;

    modport slave (
`ifdef SQRT_RSQRT_EN
        input  op_rsqrt,
`endif
        input  start, a, div_done, div_result, add_done, add_result,
        output busy, done, result, overflow, underflow, exception,
        output div_start, div_n1, div_n2, add_start, add_n1, add_n2
    );

    modport master (
`ifdef SQRT_RSQRT_EN
        output op_rsqrt,
`endif
        output start, a, div_done, div_result, add_done, add_result,
        input  busy, done, result, overflow, underflow, exception,
        input  div_start, div_n1, div_n2, add_start, add_n1, add_n2
    );
endinterface

// File: rtl/sqrt_nr_sequencer.sv
// ----------------------------------------------------------------------------
// sqrt_nr_sequencer
// Single-precision square root by Newton-Raphson x' = (m/x + x)/2 on one
// shared external divider and one shared external adder.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   io_bus  : sqrt_nr_sequencer_if.slave (issue handshake, divide and add
//             unit handshakes, result and flags)
// Optional macro SQRT_RSQRT_EN: adds op_rsqrt; the scaled root is divided
// into 1.0 to give the reciprocal square root.
// ----------------------------------------------------------------------------
module sqrt_nr_sequencer #(
    parameter int unsigned ITERS     = 3,
    parameter logic [31:0] SEED_EVEN = 32'h3F99999A,
    parameter logic [31:0] SEED_ODD  = 32'h3FD9999A,
    parameter int unsigned TIMEOUT   = 64
) (
    input logic                i_clk,
    input logic                i_rst,
    sqrt_nr_sequencer_if.slave io_bus
);
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] PINF    = 32'h7F800000;
    localparam int unsigned TW      = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        StIdle, StClassify, StDivReq, StDivWait, StAddReq, StAddWait, StScale, StDone
`ifdef SQRT_RSQRT_EN
        , StRsqReq, StRsqWait
`endif
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [31:0]     r_a;
`ifdef SQRT_RSQRT_EN
    logic            r_rsqrt;
`endif
    logic [8:0]      r_e;
    logic [31:0]     r_m;
    logic [31:0]     r_x;
    logic [31:0]     r_t;
    logic [2:0]      r_iter;
    logic [TW-1:0]   r_tmo;
    logic [31:0]     r_result;
    logic            r_underflow;
    logic            r_exception;

    logic            w_sign;
    logic [7:0]      w_exp;
    logic [22:0]     w_man;
    logic [8:0]      w_e;
    logic            w_special;
    logic [31:0]     w_spec_result;
    logic            w_spec_unf;
    logic            w_spec_exc;
    logic [2:0]      w_iter_inc;
    logic            w_tmo_hit;
    logic [31:0]     w_half;
    logic [31:0]     w_root;
    logic            w_busy;
    logic            w_done;
    logic            w_div_start;
    logic            w_add_start;

    assign w_sign     = r_a[31];
    assign w_exp      = r_a[30:23];
    assign w_man      = r_a[22:0];
    assign w_e        = {1'b0, w_exp} - 9'd127;
    assign w_iter_inc = r_iter + 3'd1;
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
    // Halve the sum by decrementing its exponent.
    assign w_half     = {io_bus.add_result[31], io_bus.add_result[30:23] - 8'd1,
                         io_bus.add_result[22:0]};
    // r_e[8:1] is the low byte of (e >>> 1), i.e. floor(e/2) mod 256.
    assign w_root     = {1'b0, r_x[30:23] + r_e[8:1], r_x[22:0]};

    // Special-operand classification, valid while in StClassify.
    always_comb begin
        w_special     = 1'b1;
        w_spec_result = QNAN;
        w_spec_unf    = 1'b0;
        w_spec_exc    = 1'b0;
        if (r_a[30:0] == 31'd0) begin
            w_spec_result = r_a;
`ifdef SQRT_RSQRT_EN
            if (r_rsqrt && !w_sign) begin
                w_spec_result = PINF;
                w_spec_exc    = 1'b1;
            end
`endif
        end else if ((w_exp == 8'hFF && w_man != 23'd0) || w_sign) begin
            w_spec_result = QNAN;
            w_spec_exc    = 1'b1;
        end else if (w_exp == 8'hFF) begin
            w_spec_result = PINF;
`ifdef SQRT_RSQRT_EN
            if (r_rsqrt) begin
                w_spec_result = 32'd0;
            end
`endif
        end else if (w_exp == 8'd0) begin
            w_spec_result = 32'd0;
            w_spec_unf    = 1'b1;
        end else begin
            w_special = 1'b0;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state != StIdle);
        w_done      = 1'b0;
        w_div_start = 1'b0;
        w_add_start = 1'b0;
        case (r_state)
            StIdle:     if (io_bus.start) w_state_nxt = StClassify;
            StClassify: w_state_nxt = w_special ? StDone : StDivReq;
            StDivReq: begin
                w_div_start = 1'b1;
                w_state_nxt = StDivWait;
            end
            StDivWait: begin
                if (io_bus.div_done)  w_state_nxt = StAddReq;
                else if (w_tmo_hit)   w_state_nxt = StDone;
            end
            StAddReq: begin
                w_add_start = 1'b1;
                w_state_nxt = StAddWait;
            end
            StAddWait: begin
                if (io_bus.add_done) begin
                    w_state_nxt = (w_iter_inc == 3'(ITERS)) ? StScale : StDivReq;
                end else if (w_tmo_hit) begin
                    w_state_nxt = StDone;
                end
            end
`ifdef SQRT_RSQRT_EN
            StScale:    w_state_nxt = r_rsqrt ? StRsqReq : StDone;
            StRsqReq: begin
                w_div_start = 1'b1;
                w_state_nxt = StRsqWait;
            end
            StRsqWait: begin
                if (io_bus.div_done || w_tmo_hit) w_state_nxt = StDone;
            end
`else
            StScale:    w_state_nxt = StDone;
`endif
            StDone: begin
                w_done      = 1'b1;
                w_state_nxt = StIdle;
            end
            default:    w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_a         <= 32'd0;
`ifdef SQRT_RSQRT_EN
            r_rsqrt     <= 1'b0;
`endif
            r_e         <= 9'd0;
            r_m         <= 32'd0;
            r_x         <= 32'd0;
            r_t         <= 32'd0;
            r_iter      <= 3'd0;
            r_tmo       <= '0;
            r_result    <= 32'd0;
            r_underflow <= 1'b0;
            r_exception <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_a         <= io_bus.a;
`ifdef SQRT_RSQRT_EN
                        r_rsqrt     <= io_bus.op_rsqrt;
`endif
                        r_underflow <= 1'b0;
                        r_exception <= 1'b0;
                    end
                end
                StClassify: begin
                    if (w_special) begin
                        r_result    <= w_spec_result;
                        r_underflow <= w_spec_unf;
                        r_exception <= w_spec_exc;
                    end else begin
                        // Reduce to [1,2) for even e, [2,4) for odd e.
                        r_e    <= w_e;
                        r_m    <= {1'b0, w_e[0] ? 8'd128 : 8'd127, w_man};
                        r_x    <= w_e[0] ? SEED_ODD : SEED_EVEN;
                        r_iter <= 3'd0;
                    end
                end
                StDivReq, StAddReq: r_tmo <= '0;
                StDivWait: begin
                    if (io_bus.div_done) begin
                        r_t <= io_bus.div_result;
                    end else if (w_tmo_hit) begin
                        r_result    <= QNAN;
                        r_exception <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                StAddWait: begin
                    if (io_bus.add_done) begin
                        r_x    <= w_half;
                        r_iter <= w_iter_inc;
                    end else if (w_tmo_hit) begin
                        r_result    <= QNAN;
                        r_exception <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                StScale: begin
`ifdef SQRT_RSQRT_EN
                    if (r_rsqrt) begin
                        // Divider operands for 1.0 / root reuse the m/x buses.
                        r_m <= 32'h3F800000;
                        r_x <= w_root;
                    end else begin
                        r_result <= w_root;
                    end
`else
                    r_result <= w_root;
`endif
                end
`ifdef SQRT_RSQRT_EN
                StRsqReq: r_tmo <= '0;
                StRsqWait: begin
                    if (io_bus.div_done) begin
                        r_result <= io_bus.div_result;
                    end else if (w_tmo_hit) begin
                        r_result    <= QNAN;
                        r_exception <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign io_bus.busy      = w_busy;
    assign io_bus.done      = w_done;
    assign io_bus.result    = r_result;
    assign io_bus.overflow  = 1'b0;
    assign io_bus.underflow = r_underflow;
    assign io_bus.exception = r_exception;
    assign io_bus.div_start = w_div_start;
    assign io_bus.div_n1    = r_m;
    assign io_bus.div_n2    = r_x;
    assign io_bus.add_start = w_add_start;
    assign io_bus.add_n1    = r_t;
    assign io_bus.add_n2    = r_x;
endmodule

// File: doc/sqrt_nr_sequencer.md
Name: sqrt_nr_sequencer

Overview:
- Multi-cycle controller that computes IEEE-754 single-precision square root by Newton-Raphson iteration on time-shared external divide and add units.
- Replaces the unrolled per-iteration instances with one divider and one adder, driven through start/done handshakes.
- Sits between the FPU issue logic (start/busy/done) and the shared DivFPU/AddSubFPU instances; the adder is used in add mode only.

Parameters:
- ITERS, 3, number of NR iterations (1..7); ITERS >= 3 required for <= 1 ulp.
- SEED_EVEN, 32'h3F99999A, seed (1.2) for reduced operand in [1,2).
- SEED_ODD, 32'h3FD9999A, seed (1.7) for reduced operand in [2,4).
- TIMEOUT, 64, max cycles in any WAIT state before abort.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; accepted only when busy=0.
- a  in  32  operand, captured on accepted start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result/flags valid.
- result  out  32  sqrt(a); held until next accepted start.
- overflow  out  1  constant 0.
- underflow  out  1  denormal input flushed.
- exception  out  1  invalid input or unit timeout.
- div_start  out  1  one-cycle divide request.
- div_n1, div_n2  out  32 each  dividend, divisor; stable from div_start until div_done.
- div_done  in  1  divide complete.
- div_result  in  32  quotient.
- add_start  out  1  one-cycle add request.
- add_n1, add_n2  out  32 each  addends; stable until add_done.
- add_done  in  1  add complete.
- add_result  in  32  sum.

Behaviour:
- Reset: state IDLE; busy, done, underflow, exception, div_start, add_start = 0; result and all operand buses = 0; iteration and timeout counters = 0.
- States: IDLE, CLASSIFY, DIV_REQ, DIV_WAIT, ADD_REQ, ADD_WAIT, SCALE, DONE.
- IDLE: on start, capture a -> CLASSIFY. A start while busy=1 is ignored, including in DONE.
- CLASSIFY, special cases go straight to DONE with no unit activity:
  - +0 / -0 -> same value.
  - +inf -> +inf.
  - NaN or any negative nonzero -> 32'h7FC00000, exception=1.
  - E=0 with M!=0 -> +0, underflow=1.
- CLASSIFY, normal operand: e = E-127 (signed 9-bit).
  - e even: m = {0,8'd127,M}, x = SEED_EVEN.
  - e odd: m = {0,8'd128,M}, x = SEED_ODD.
  - Iteration counter = 0; next state DIV_REQ.
- DIV_REQ: div_start=1, div_n1=m, div_n2=x -> DIV_WAIT.
- DIV_WAIT: on div_done, t = div_result -> ADD_REQ.
- ADD_REQ: add_start=1, add_n1=t, add_n2=x -> ADD_WAIT.
- ADD_WAIT: on add_done, x = {add_result[31], add_result[30:23]-1, add_result[22:0]} (halving); increment counter.
  - counter==ITERS -> SCALE, else DIV_REQ.
- Unit done inputs are sampled only in their own WAIT state; a stray or late done is ignored.
- SCALE: result = {0, x[30:23] + (e>>>1), x[22:0]} (arithmetic shift = floor). The sum cannot overflow or underflow the field -> DONE.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- Timeout: counter counts cycles in each WAIT and clears on entry. Reaching TIMEOUT -> result 32'h7FC00000, exception=1, DONE.
- Latency, start-accept cycle to done cycle:
  - specials = 2.
  - normal = 3 + ITERS*(Ldiv+Ladd+2), where L is start-to-done latency of a unit (L >= 1). ITERS=3, L=1 gives 15.
- Flags clear on each accepted start.
- rst mid-operation aborts at once: no done pulse; in-flight unit results discarded.

Optional Feature:
- Macro: SQRT_RSQRT_EN.
- Defined: input op_rsqrt (1 bit) captured with a. When set, SCALE continues to RSQ_REQ/RSQ_WAIT: div_n1=32'h3F800000, div_n2=scaled root; result = div_result. This adds Ldiv+1 cycles.
  - rsqrt(+0) -> +inf with exception=1.
  - rsqrt(+inf) -> +0.
  - Other specials as for sqrt.
- Undefined: port absent; sqrt only.

Test Plan:
- a=32'h40800000 (4.0), units L=1 -> result 32'h40000000 exact, done 15 cycles after start, exactly 3 div_start and 3 add_start pulses.
- a=32'h40000000 (2.0) and 32'h3E800000 (0.25) -> 32'h3FB504F3 ±1 ulp and 32'h3F000000; repeat with Ldiv=5, Ladd=3 -> same values, latency 3+3*10=33.
- a=32'hBF800000 -> 32'h7FC00000, exception=1, done at cycle 2, no unit starts; a=32'h00000001 -> 0, underflow=1.
- start pulsed every cycle during a 4.0 operation -> only the first is accepted; single done; the next start is accepted only in IDLE.
- rst asserted in DIV_WAIT, then div_done pulsed -> no done, busy=0 next cycle, all outputs at reset values.
- div_done held 0 -> after 64 WAIT cycles result 32'h7FC00000, exception=1, done pulse.
